gradient_engine: RTL and testbench

Parametrised successor to the single-mode gradient stage. It reads a BRAM image and writes signed x and y central-difference gradients into two BRAMs. Added over the previous generation: configurable BRAM read latency, back-to-back pipelined reads, a runtime halved/full-scale mode, a widened signed output that cannot overflow, simultaneous x/y writes, and a busy flag. It sits between the blur/octave stage and keypoint orientation in the SIFT pipeline.

---
 rtl/gradient_pkg.sv | 20 ++
 rtl/read_tag_pipe.sv | 34 +++
 rtl/gradient_engine.sv | 174 +++++++++++++++++
 tb/tb_gradient_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types and encodings for the central-difference gradient stage.
package gradient_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE
   } state_t;

   localparam logic MODE_HALF = 1'b0;
   localparam logic MODE_FULL = 1'b1;

   // Tag values double as the issue-order index within a pixel.
   localparam logic [1:0] TAG_L = 2'd0;
   localparam logic [1:0] TAG_R = 2'd1;
   localparam logic [1:0] TAG_U = 2'd2;
   localparam logic [1:0] TAG_D = 2'd3;

endpackage

// File: rtl/read_tag_pipe.sv
// Delays each read strobe and its neighbour tag so they line up with the
// returning source-BRAM data; reset discards anything in flight.
module read_tag_pipe #(
   parameter int READ_LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vld,
   input  logic [1:0] tag,
   output logic       dly_vld,
   output logic [1:0] dly_tag
);

   logic [READ_LATENCY-1:0] vld_sr;
   logic [1:0]              tag_sr [READ_LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr <= '0;
         for (int i = 0; i < READ_LATENCY; i++) tag_sr[i] <= '0;
      end else begin
         vld_sr[0] <= vld;
         tag_sr[0] <= tag;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            tag_sr[i] <= tag_sr[i-1];
         end
      end
   end

   assign dly_vld = vld_sr[READ_LATENCY-1];
   assign dly_tag = tag_sr[READ_LATENCY-1];

endmodule

// File: rtl/gradient_engine.sv
// Raster-scans a source image, fetching L/R/U/D neighbours per pixel, and writes
// signed x/y central differences; one pixel every READ_LATENCY+5 cycles.
module gradient_engine
   import gradient_pkg::*;
#(
   parameter int  WIDTH        = 64,
   parameter int  HEIGHT       = 64,
   parameter int  BIT_DEPTH    = 8,
   parameter int  READ_LATENCY = 2,
   localparam int ADDR_W       = $clog2(WIDTH*HEIGHT)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic                 mode_in,
   output logic                 busy_out,
   output logic                 gradient_done,
   output logic [ADDR_W-1:0]    ext_read_addr,
   output logic                 ext_read_addr_valid,
   input  logic [BIT_DEPTH-1:0] ext_pixel_in,
   output logic [ADDR_W-1:0]    x_write_addr,
   output logic [ADDR_W-1:0]    y_write_addr,
   output logic                 x_write_valid,
   output logic                 y_write_valid,
   output logic [BIT_DEPTH:0]   x_pixel_out,
   output logic [BIT_DEPTH:0]   y_pixel_out
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   state_t                 state, state_d;
   logic [1:0]             cnt, cnt_d, issue_tag, rd_tag, pipe_tag;
   logic                   issue, launch, emit, pipe_vld, mode, last;
   logic [XW-1:0]          cx, col;
   logic [YW-1:0]          cy, row;
   logic [BIT_DEPTH:0]     pl, pr, pu, pd;
   logic signed [BIT_DEPTH:0] dx_raw, dy_raw, dx_half, dy_half;

   read_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_pipe (
      .clk     (clk_in),
      .rst     (rst_in),
      .vld     (ext_read_addr_valid),
      .tag     (rd_tag),
      .dly_vld (pipe_vld),
      .dly_tag (pipe_tag)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // The WRITE cycle also issues the next pixel's L read so pixels pipeline back to back.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      issue     = 1'b0;
      issue_tag = cnt;
      launch    = 1'b0;
      emit      = 1'b0;
      case (state)
         ST_IDLE: if (start_in) begin
            launch    = 1'b1;
            issue     = 1'b1;
            issue_tag = TAG_L;
            cnt_d     = 2'd1;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            issue = 1'b1;
            cnt_d = cnt + 2'd1;
            if (cnt == TAG_D) state_d = ST_WAIT;
         end
         ST_WAIT: if (pipe_vld && pipe_tag == TAG_D) begin
            emit    = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: if (gradient_done) begin
            state_d = ST_IDLE;
         end else begin
            issue     = 1'b1;
            issue_tag = TAG_L;
            cnt_d     = 2'd1;
            state_d   = ST_ISSUE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Neighbour coordinates clamp at the borders, replicating edge pixels.
   always_comb begin
      col = cx;
      row = cy;
      case (issue_tag)
         TAG_L:   col = (cx == '0) ? cx : cx - XW'(1);
         TAG_R:   col = (cx == XW'(WIDTH-1)) ? cx : cx + XW'(1);
         TAG_U:   row = (cy == '0) ? cy : cy - YW'(1);
         default: row = (cy == YW'(HEIGHT-1)) ? cy : cy + YW'(1);
      endcase
   end

   // D is taken straight off the bus in the cycle it arrives.
   assign pd   = {1'b0, ext_pixel_in};
   assign last = (cx == XW'(WIDTH-1)) && (cy == YW'(HEIGHT-1));

   always_comb begin
      dx_raw  = pr - pl;
      dy_raw  = pd - pu;
      dx_half = dx_raw >>> 1;
      dy_half = dy_raw >>> 1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ext_read_addr       <= '0;
         ext_read_addr_valid <= 1'b0;
         rd_tag              <= TAG_L;
         mode                <= MODE_HALF;
         cx                  <= '0;
         cy                  <= '0;
         pl                  <= '0;
         pr                  <= '0;
         pu                  <= '0;
         x_write_addr        <= '0;
         x_write_valid       <= 1'b0;
         x_pixel_out         <= '0;
         y_pixel_out         <= '0;
         gradient_done       <= 1'b0;
      end else begin
         ext_read_addr_valid <= issue;
         x_write_valid       <= emit;
         gradient_done       <= emit && last;
         if (issue) begin
            ext_read_addr <= ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
            rd_tag        <= issue_tag;
         end
         if (launch) begin
            mode <= mode_in;
            cx   <= '0;
            cy   <= '0;
         end
         if (pipe_vld) begin
            case (pipe_tag)
               TAG_L:   pl <= pd;
               TAG_R:   pr <= pd;
               TAG_U:   pu <= pd;
               default: ;
            endcase
         end
         if (emit) begin
            x_write_addr <= ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
            x_pixel_out  <= (mode == MODE_FULL) ? dx_raw : dx_half;
            y_pixel_out  <= (mode == MODE_FULL) ? dy_raw : dy_half;
            if (cx == XW'(WIDTH-1)) begin
               cx <= '0;
               cy <= last ? '0 : cy + YW'(1);
            end else begin
               cx <= cx + XW'(1);
            end
         end
      end
   end

   assign y_write_addr  = x_write_addr;
   assign y_write_valid = x_write_valid;
   assign busy_out      = (state != ST_IDLE);

endmodule

// File: tb/tb_gradient_engine.sv
// Runs three 4x4 engines (read latency 2, 1, 4) side by side against one image
// and checks every write against a neighbour-difference reference model.
module tb_gradient_engine;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int N  = W*H;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst, start, mode, clr;
   logic [7:0] img [N];
   int cyc = 0;
   int s_cyc;
   int n_cmp = 0;
   int n_bad = 0;

   logic       busy [NI], done [NI], rvld [NI], xv [NI], yv [NI];
   logic [3:0] raddr [NI], xa [NI], ya [NI];
   logic [7:0] pix [NI];
   logic [8:0] xd [NI], yd [NI];

   int         wcnt [NI], dcnt [NI], rcnt [NI], pairbad [NI], done_cyc [NI];
   logic       busy_done [NI];
   logic [3:0] ra [NI][N];
   logic [8:0] rx [NI][N], ry [NI][N];
   int         rc [NI][N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RL = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [3:0] pa [RL];
      always @(posedge clk) begin
         pa[0] <= raddr[g];
         for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
      end
      assign pix[g] = img[pa[RL-1]];

      gradient_engine #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .READ_LATENCY(RL)) u_dut (
         .clk_in              (clk),
         .rst_in              (rst),
         .start_in            (start),
         .mode_in             (mode),
         .busy_out            (busy[g]),
         .gradient_done       (done[g]),
         .ext_read_addr       (raddr[g]),
         .ext_read_addr_valid (rvld[g]),
         .ext_pixel_in        (pix[g]),
         .x_write_addr        (xa[g]),
         .y_write_addr        (ya[g]),
         .x_write_valid       (xv[g]),
         .y_write_valid       (yv[g]),
         .x_pixel_out         (xd[g]),
         .y_pixel_out         (yd[g])
      );
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (clr) begin
            wcnt[g]     <= 0;
            dcnt[g]     <= 0;
            rcnt[g]     <= 0;
            pairbad[g]  <= 0;
            done_cyc[g] <= -1;
            busy_done[g] <= 1'b0;
         end else begin
            if (rvld[g]) rcnt[g] <= rcnt[g] + 1;
            if (xv[g] !== yv[g] || (xv[g] && xa[g] !== ya[g])) pairbad[g] <= pairbad[g] + 1;
            if (xv[g]) begin
               if (wcnt[g] < N) begin
                  ra[g][wcnt[g]] <= xa[g];
                  rx[g][wcnt[g]] <= xd[g];
                  ry[g][wcnt[g]] <= yd[g];
                  rc[g][wcnt[g]] <= cyc;
               end
               wcnt[g] <= wcnt[g] + 1;
            end
            if (done[g]) begin
               dcnt[g]      <= dcnt[g] + 1;
               done_cyc[g]  <= cyc;
               busy_done[g] <= busy[g];
            end
         end
      end
   end

   function automatic int rl_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference gradient: difference of the two clamped neighbours, halved by floor division in mode 0.
   function automatic logic [8:0] ref_grad(input int hi, input int lo, input logic m);
      int d;
      d = hi - lo;
      if (!m) d = d >>> 1;
      return 9'(d);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input logic m);
      int px, py, p;
      logic [8:0] ex, ey;
      for (int g = 0; g < NI; g++) begin
         p = rl_of(g) + 5;
         chk($sformatf("writes g%0d", g), wcnt[g], N);
         chk($sformatf("reads g%0d", g), rcnt[g], 4*N);
         chk($sformatf("done_pulses g%0d", g), dcnt[g], 1);
         chk($sformatf("xy_pairing g%0d", g), pairbad[g], 0);
         chk($sformatf("done_cycle g%0d", g), done_cyc[g] - s_cyc + 1, N*p);
         chk($sformatf("busy_at_done g%0d", g), 32'(busy_done[g]), 1);
         for (int i = 0; i < N; i++) begin
            px = i % W;
            py = i / W;
            ex = ref_grad(img[py*W + imin(px+1, W-1)], img[py*W + imax(px-1, 0)], m);
            ey = ref_grad(img[imin(py+1, H-1)*W + px], img[imax(py-1, 0)*W + px], m);
            chk($sformatf("addr g%0d i%0d", g, i), ra[g][i], i);
            chk($sformatf("x g%0d i%0d", g, i), rx[g][i], ex);
            chk($sformatf("y g%0d i%0d", g, i), ry[g][i], ey);
            chk($sformatf("wcycle g%0d i%0d", g, i), rc[g][i] - s_cyc + 1, (i+1)*p);
         end
      end
   endtask

   task automatic run_frame(input logic m, input bit pulse_mid);
      int budget;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b1;
      mode  = m;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode  = 1'($urandom_range(0, 1));
      s_cyc = cyc;
      chk("busy_after_start", 32'(busy[0] & busy[1] & busy[2]), 1);
      budget = 0;
      while ((dcnt[0] == 0 || dcnt[1] == 0 || dcnt[2] == 0) && budget < 400) begin
         @(negedge clk);
         budget++;
         if (pulse_mid && budget == 30) begin
            start = 1'b1;
            mode  = ~m;
         end else if (pulse_mid && budget == 31) begin
            start = 1'b0;
         end
      end
      chk("frame_in_budget", 32'(budget < 400), 1);
      repeat (3) @(negedge clk);
      chk("busy_after_done", 32'(busy[0] | busy[1] | busy[2]), 0);
      check_frame(m);
   endtask

   task automatic chk_all_zero(input string tag);
      for (int g = 0; g < NI; g++)
         chk($sformatf("%s g%0d", tag, g),
             32'(|{busy[g], done[g], rvld[g], xv[g], yv[g], raddr[g], xa[g], ya[g], xd[g], yd[g]}), 0);
   endtask

   task automatic rand_img();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      clr   = 1'b1;
      for (int i = 0; i < N; i++) img[i] = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Ramp image p = 10x + 40y, full then halved scale.
      for (int i = 0; i < N; i++) img[i] = 8'(10*(i % W) + 40*(i / W));
      run_frame(1'b1, 1'b0);
      chk("t1 x interior", rx[0][5], 20);
      chk("t1 x edge", rx[0][0], 10);
      chk("t1 y interior", ry[0][5], 80);
      chk("t1 y edge", ry[0][0], 40);
      chk("t1 done cycle", done_cyc[0] - s_cyc + 1, 112);
      chk("t4 spacing rl1", rc[1][5] - rc[1][4], 6);
      chk("t4 spacing rl4", rc[2][5] - rc[2][4], 9);
      run_frame(1'b0, 1'b0);
      chk("t2 x interior", rx[0][5], 10);
      chk("t2 x edge", rx[0][0], 5);
      chk("t2 y interior", ry[0][5], 40);
      chk("t2 y edge", ry[0][0], 20);

      // Extreme negative difference at the left border.
      rand_img();
      img[0] = 8'd255;
      img[1] = 8'd0;
      img[2] = 8'd0;
      img[3] = 8'd0;
      run_frame(1'b1, 1'b0);
      chk("t3 x full", rx[0][0], 9'h101);
      run_frame(1'b0, 1'b0);
      chk("t3 x half", rx[0][0], 9'h180);

      for (int f = 0; f < 4; f++) begin
         rand_img();
         run_frame(1'($urandom_range(0, 1)), 1'b0);
      end

      // A second start mid-frame must be ignored.
      rand_img();
      run_frame(1'b1, 1'b1);

      // Asynchronous reset partway through a frame, then a clean restart.
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b1;
      mode  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rand_img();
      run_frame(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
